// File: rtl/wall_datapath.sv
// Wall datapath: slides a gapped vertical wall leftward, streams erase/paint pixels, flags player collision.
// Optional WALL_GAP_RANDOM_EN selects an LFSR-driven gap position instead of the fixed GAP_Y.
module wall_datapath #(
    parameter int         X_START     = 159,
    parameter int         HEIGHT      = 120,
    parameter int         GAP_H       = 30,
    parameter int         GAP_Y       = 45,
    parameter int         PLAYER_X    = 20,
    parameter int         MOVE_DIV    = 833333,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic [6:0] player_y,
    output logic       touched,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] wall_x,
    output logic [2:0] dbg_state
);

    // Valid/ready note: there is no handshake here; control presents a state code every
    // cycle and the VGA adapter accepts every cycle in which plot is high.
    localparam logic [3:0] ST_READY = 4'b0101;
    localparam logic [3:0] ST_MOVE  = 4'b0110;

    localparam int              CW       = $clog2(MOVE_DIV + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MOVE_DIV - 1);
    localparam logic [6:0]      ROW_LAST = 7'(HEIGHT - 1);
    localparam logic [7:0]      XS       = 8'(X_START);
    localparam logic [7:0]      PX       = 8'(PLAYER_X);

    typedef enum logic [2:0] {
        ENG_IDLE   = 3'd0,
        ENG_ERASE  = 3'd1,
        ENG_UPDATE = 3'd2,
        ENG_PAINT  = 3'd3,
        ENG_CHECK  = 3'd4
    } eng_e;

    eng_e          eng_q, eng_d;
    logic [6:0]    row_q, row_d;
    logic [7:0]    wall_x_q, wall_x_d;
    logic [6:0]    gap_q, gap_d;
    logic          touched_q, touched_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;

    logic [6:0]    gap_src;
    logic [7:0]    gap_sum;
    logic [7:0]    gap_hi;
    logic          row_in_gap;
    logic          player_in_gap;
    logic          tick_wrap;

`ifdef WALL_GAP_RANDOM_EN
    logic [7:0] lfsr_q;

    // x^8+x^6+x^5+x^4+1, free-running so the gap depends on when READY is seen
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign gap_src = 7'(lfsr_q % 8'(HEIGHT - GAP_H + 1));
`else
    assign gap_src = 7'(GAP_Y);
`endif

    // Gap end is exclusive and never runs past the bottom row.
    assign gap_sum       = {1'b0, gap_q} + 8'(GAP_H);
    assign gap_hi        = (gap_sum > 8'(HEIGHT)) ? 8'(HEIGHT) : gap_sum;
    assign row_in_gap    = (row_q >= gap_q) && ({1'b0, row_q} < gap_hi);
    assign player_in_gap = (player_y >= gap_q) && ({1'b0, player_y} < gap_hi);
    assign tick_wrap     = (cnt_q == CNT_LAST);

    always_comb begin
        eng_d     = eng_q;
        row_d     = row_q;
        wall_x_d  = wall_x_q;
        gap_d     = gap_q;
        touched_d = touched_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        plot_d    = 1'b0;
        busy_d    = (eng_q != ENG_IDLE);
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;

        if (state == ST_READY) begin
            wall_x_d  = XS;
            gap_d     = gap_src;
            touched_d = 1'b0;
            cnt_d     = '0;
            pend_d    = 1'b0;
            eng_d     = ENG_IDLE;
            row_d     = '0;
            busy_d    = 1'b0;
        end else begin
            cnt_d = tick_wrap ? '0 : cnt_q + CW'(1);
            case (eng_q)
                ENG_IDLE: begin
                    if (state == ST_MOVE && pend_q && !touched_q) begin
                        pend_d = 1'b0;
                        eng_d  = ENG_ERASE;
                        row_d  = '0;
                    end
                end
                ENG_ERASE: begin
                    plot_d   = 1'b1;
                    x_d      = wall_x_q;
                    y_d      = row_q;
                    colour_d = 3'b000;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        eng_d = ENG_UPDATE;
                    end else begin
                        row_d = row_q + 7'd1;
                    end
                end
                ENG_UPDATE: begin
                    if (wall_x_q == 8'd0) begin
                        wall_x_d = XS;
                        gap_d    = gap_src;
                    end else begin
                        wall_x_d = wall_x_q - 8'd1;
                    end
                    row_d = '0;
                    eng_d = ENG_PAINT;
                end
                ENG_PAINT: begin
                    plot_d   = 1'b1;
                    x_d      = wall_x_q;
                    y_d      = row_q;
                    colour_d = row_in_gap ? 3'b000 : WALL_COLOUR;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        eng_d = ENG_CHECK;
                    end else begin
                        row_d = row_q + 7'd1;
                    end
                end
                ENG_CHECK: begin
                    if (wall_x_q == PX && !player_in_gap) touched_d = 1'b1;
                    eng_d = ENG_IDLE;
                end
                default: eng_d = ENG_IDLE;
            endcase
            // A tick landing on the step-start edge must not be lost.
            if (tick_wrap) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eng_q     <= ENG_IDLE;
            row_q     <= '0;
            wall_x_q  <= XS;
            gap_q     <= 7'(GAP_Y);
            touched_q <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
        end else begin
            eng_q     <= eng_d;
            row_q     <= row_d;
            wall_x_q  <= wall_x_d;
            gap_q     <= gap_d;
            touched_q <= touched_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
        end
    end

    assign touched   = touched_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign wall_x    = wall_x_q;
    assign dbg_state = eng_q;

endmodule

// File: tb/tb_wall_datapath.sv
// Bench for wall_datapath: operation-queue reference model checked every cycle plus directed literal checks.
module tb_wall_datapath;

    localparam int         X_START  = 159;
    localparam int         HEIGHT   = 8;
    localparam int         GAP_H    = 3;
    localparam int         GAP_Y    = 2;
    localparam int         PLAYER_X = 20;
    localparam int         MOVE_DIV = 4;
    localparam logic [2:0] WCOL     = 3'b010;

    localparam logic [3:0] C_READY = 4'b0101;
    localparam logic [3:0] C_MOVE  = 4'b0110;
    localparam logic [3:0] C_STOP  = 4'b0111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] state = 4'b0000;
    logic [6:0] player_y = 7'd3;
    logic       touched;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic [7:0] wall_x;
    logic [2:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    wall_datapath #(
        .X_START(X_START), .HEIGHT(HEIGHT), .GAP_H(GAP_H), .GAP_Y(GAP_Y),
        .PLAYER_X(PLAYER_X), .MOVE_DIV(MOVE_DIV), .WALL_COLOUR(WCOL)
    ) dut (
        .clk(clk), .reset(reset), .state(state), .player_y(player_y),
        .touched(touched), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .wall_x(wall_x), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each step is a list of operations, one per cycle: erase rows, move, paint rows, check.
    localparam logic [1:0] OP_ERASE = 2'd0, OP_UPDATE = 2'd1, OP_PAINT = 2'd2, OP_CHECK = 2'd3;
    logic [8:0] exp_q[$];

    int         m_wall_x  = X_START;
    int         m_gap     = GAP_Y;
    int         m_tick    = 0;
    bit         m_pend    = 1'b0;
    bit         m_touched = 1'b0;
    logic [7:0] m_lfsr    = 8'hA5;
    bit         e_plot, e_busy;
    int         e_x, e_y, e_c;

    function automatic int gap_source();
`ifdef WALL_GAP_RANDOM_EN
        return int'(m_lfsr) % (HEIGHT - GAP_H + 1);
`else
        return GAP_Y;
`endif
    endfunction

    function automatic bit in_gap(input int r);
        int hi;
        hi = m_gap + GAP_H;
        if (hi > HEIGHT) hi = HEIGHT;
        return (r >= m_gap) && (r < hi);
    endfunction

    always begin
        logic [8:0] op;
        bit         wrap;
        @(posedge clk);
        e_plot = 1'b0;
        e_busy = 1'b0;
        if (reset) begin
            m_wall_x = X_START; m_gap = GAP_Y; m_tick = 0; m_pend = 0; m_touched = 0;
            exp_q.delete();
        end else if (state == C_READY) begin
            m_wall_x = X_START; m_gap = gap_source(); m_tick = 0; m_pend = 0; m_touched = 0;
            exp_q.delete();
        end else begin
            wrap   = (m_tick + 1 == MOVE_DIV);
            m_tick = wrap ? 0 : m_tick + 1;
            if (exp_q.size() > 0) begin
                op     = exp_q.pop_front();
                e_busy = 1'b1;
                case (op[8:7])
                    OP_ERASE: begin e_plot = 1; e_x = m_wall_x; e_y = int'(op[6:0]); e_c = 0; end
                    OP_UPDATE: begin
                        if (m_wall_x == 0) begin m_wall_x = X_START; m_gap = gap_source(); end
                        else m_wall_x = m_wall_x - 1;
                    end
                    OP_PAINT: begin
                        e_plot = 1; e_x = m_wall_x; e_y = int'(op[6:0]);
                        e_c = in_gap(e_y) ? 0 : int'(WCOL);
                    end
                    default: if (m_wall_x == PLAYER_X && !in_gap(int'(player_y))) m_touched = 1;
                endcase
            end else if (state == C_MOVE && m_pend && !m_touched) begin
                m_pend = 0;
                for (int r = 0; r < HEIGHT; r++) exp_q.push_back({OP_ERASE, 7'(r)});
                exp_q.push_back({OP_UPDATE, 7'd0});
                for (int r = 0; r < HEIGHT; r++) exp_q.push_back({OP_PAINT, 7'(r)});
                exp_q.push_back({OP_CHECK, 7'd0});
            end
            if (wrap) m_pend = 1;
        end
        if (reset) m_lfsr = 8'hA5;
        else       m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        #1;
        chk("cyc_plot", {31'd0, plot}, {31'd0, e_plot});
        chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
        chk("cyc_wall_x", {24'd0, wall_x}, m_wall_x);
        chk("cyc_touched", {31'd0, touched}, {31'd0, m_touched});
        if (e_plot) begin
            chk("cyc_x", {24'd0, x}, e_x);
            chk("cyc_y", {25'd0, y}, e_y);
            chk("cyc_colour", {29'd0, colour}, e_c);
        end
    end

    // ---------------- driver helpers ----------------
    // what: 0 wall_x==val, 1 touched==val, 2 busy==val, 3 plot (and x==val when val>=0)
    task automatic wait_for(input int what, input int val, input int budget, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = (int'(wall_x) == val);
                1:       hit = (int'(touched) == val);
                2:       hit = (int'(busy) == val);
                default: hit = plot && (val < 0 || int'(x) == val);
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles", name, budget);
        end
    endtask

    task automatic go_ready(input int cycles);
        @(negedge clk);
        state = C_READY;
        repeat (cycles - 1) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    logic [17:0] cap_q[$];
    logic [2:0]  paint_c[8];

    initial begin
        int  nb;
        bit  done;
        paint_c = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};

        // reset two cycles, then READY
        repeat (2) @(negedge clk);
        reset = 1'b0;
        state = C_READY;
        @(negedge clk);
        chk("rst_wall_x", {24'd0, wall_x}, 159);
        chk("rst_touched", {31'd0, touched}, 0);
        chk("rst_plot", {31'd0, plot}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // single step, capture the pixel stream
        state = C_MOVE;
        nb = 0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (plot) cap_q.push_back({x, y, colour});
            if (busy) nb++;
            if (busy && state == C_MOVE) state = C_STOP;
            if (nb > 0 && !busy) done = 1;
        end
        if (!done) begin n_cmp++; n_fail++; $display("FAIL step_timeout: no complete step"); end
        chk("step_busy_cycles", nb, 18);
        chk("step_pixel_count", cap_q.size(), 16);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            chk("erase_pixel", {14'd0, cap_q[i]}, {14'd0, 8'd159, 7'(i), 3'd0});
        for (int i = 0; i < 8 && i + 8 < cap_q.size(); i++)
            chk("paint_pixel", {14'd0, cap_q[i+8]}, {14'd0, 8'd158, 7'(i), paint_c[i]});

        // run to column 0 passing the player inside the gap, then wrap
        @(negedge clk);
        player_y = 7'd3;
        state = C_MOVE;
        wait_for(0, 0, 6000, "reach_x0");
        chk("pass_touched", {31'd0, touched}, 0);
        wait_for(2, 0, 40, "x0_step_end");
        wait_for(3, -1, 40, "wrap_erase");
        chk("wrap_erase_x", {24'd0, x}, 0);
        wait_for(0, 159, 40, "wrap_x159");
        wait_for(3, -1, 40, "wrap_paint");
        chk("wrap_paint_x", {24'd0, x}, 159);
        chk("wrap_paint_y", {25'd0, y}, 0);
        chk("wrap_paint_c", {29'd0, colour}, 2);

        // collision with player outside the gap
        go_ready(3);
        chk("ready_wall_x", {24'd0, wall_x}, 159);
        player_y = 7'd0;
        state = C_MOVE;
        wait_for(1, 1, 4000, "touch_rise");
        chk("touch_wall_x", {24'd0, wall_x}, 20);
        state = C_STOP;
        repeat (5) @(negedge clk);
        chk("touch_hold_stop", {31'd0, touched}, 1);
        state = C_MOVE;
        repeat (25) @(negedge clk);
        chk("touch_blocks_x", {24'd0, wall_x}, 20);
        chk("touch_blocks_busy", {31'd0, busy}, 0);
        state = C_READY;
        @(negedge clk);
        chk("touch_clear", {31'd0, touched}, 0);
        chk("touch_clear_x", {24'd0, wall_x}, 159);

        // abort mid-paint
        state = C_MOVE;
        wait_for(3, 158, 60, "abort_paint");
        state = C_READY;
        @(negedge clk);
        chk("abort_plot", {31'd0, plot}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_wall_x", {24'd0, wall_x}, 159);
        repeat (2) @(negedge clk);

        // reset mid-sweep
        state = C_MOVE;
        wait_for(2, 1, 60, "rst_sweep_busy");
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sweep_plot", {31'd0, plot}, 0);
        chk("rst_sweep_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sweep_quiet", {31'd0, plot}, 0);

        // two READY->MOVE rounds; gap rows follow the gap source
        for (int k = 0; k < 2; k++) begin
            go_ready(2 + k);
            state = C_MOVE;
            wait_for(2, 1, 60, "round_busy");
            wait_for(2, 0, 40, "round_done");
        end

        go_ready(2);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // hard stop so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wall_datapath.md
# wall_datapath

Datapath partner of the wall control FSM. Consumes the 4-bit wall state code and returns `touched`, closing the go/touched loop. Moves a vertical wall leftward across the 160x120 VGA framebuffer one column per rate tick. Streams erase/redraw pixels to the VGA adapter and flags a collision with the player column.

## Interface
- `X_START`, 159: spawn column, also the wrap target.
- `HEIGHT`, 120: wall height in rows, starting at y=0.
- `GAP_H`, 30: height of the opening, in rows.
- `GAP_Y`, 45: top row of the opening (fixed-gap build).
- `PLAYER_X`, 20: player column used for the collision test.
- `MOVE_DIV`, 833333: clocks per move tick.
- `WALL_COLOUR`, 3'b010: colour of wall pixels.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `state`  in  4  wall control state: 4'b0101 READY, 4'b0110 MOVE, 4'b0111 STOP, 4'b1000 DRAW
- `player_y`  in  7  player row
- `touched`  out  1  collision flag to control
- `x`  out  8  pixel x to VGA adapter
- `y`  out  7  pixel y to VGA adapter
- `colour`  out  3  pixel colour
- `plot`  out  1  pixel write enable
- `busy`  out  1  pixel engine active
- `wall_x`  out  8  current wall column

## Operation
- **Registers:** `wall_x`, `gap_y`, tick counter, `tick_pend`, engine FSM, row counter, `touched`.
- **Engine states:** IDLE, ERASE, UPDATE, PAINT, CHECK.
- **READY (4'b0101), every cycle:**
  - `wall_x`←X_START.
  - `gap_y`←gap source.
  - `touched`←0.
  - Tick counter←0 and `tick_pend`←0.
  - Engine forced to IDLE, aborting any sweep; `plot`←0.
- **Other codes:** tick counter runs 0..MOVE_DIV-1; sets `tick_pend` on wrap.
- **Step start:** when `state`==MOVE, `tick_pend`, engine IDLE and `touched`==0:
  - clear `tick_pend`;
  - go to ERASE with row=0.
- **ERASE:**
  - each cycle emits `plot`=1, x=`wall_x`, y=row, colour=0;
  - row 0..HEIGHT-1, then UPDATE.
- **UPDATE:**
  - `plot`=0;
  - `wall_x`←`wall_x`-1, or X_START if `wall_x`==0 (wrap; `gap_y` re-sourced on wrap);
  - row←0.
- **PAINT:**
  - each cycle emits `plot`=1 at the new `wall_x`, y=row;
  - colour=0 if `gap_y` ≤ row < `gap_y`+GAP_H, else WALL_COLOUR;
  - then CHECK.
- **CHECK:**
  - `plot`=0;
  - if `wall_x`==PLAYER_X and `player_y` is outside the gap, `touched`←1;
  - then IDLE.
- **STOP/DRAW codes:** no new step starts, but an in-progress sweep completes.
- **`touched` hold:** stays high until READY is observed, so control sees it in both MOVE and STOP.
- **Gap clamp:** if `gap_y`+GAP_H > HEIGHT, the gap is clamped to end at HEIGHT-1.

## Timing
- **Reset values:** all outputs 0 after reset; `wall_x` = X_START; engine IDLE.
- **Outputs:** all registered; pixel outputs change one cycle after the engine state/row.
- **Step length:** exactly 2·HEIGHT+2 cycles; `busy`=1 throughout.
- **First erase pixel:** appears the cycle after step start.
- **`touched` latency:** rises on the clock edge ending CHECK; visible to control the next cycle.
- **Simultaneous tick wrap and step start:** `tick_pend` ends set (set wins).
- **`reset` during sweep:** engine IDLE and `plot`=0 next cycle; no further pixels emitted.
- **MOVE_DIV < 2·HEIGHT+2:** ticks coalesce into one pending step, never queued.

## Configuration
- `WALL_GAP_RANDOM_EN` defined:
  - 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every clock;
  - gap source is LFSR mod (HEIGHT-GAP_H+1).
- Undefined:
  - gap source is constant GAP_Y;
  - no LFSR logic is built.

## Test plan
- **Reset and idle:** `reset`=1 two cycles, then `state`=READY → `wall_x`=159, `touched`=0, `plot`=0, `busy`=0.
- **Single step:** MOVE_DIV=4, HEIGHT=8, GAP_Y=2, GAP_H=3; `state`=MOVE → 8 pixels at x=159 colour 0, then 8 pixels at x=158 with rows 2–4 colour 0 and the rest 3'b010; 18 busy cycles.
- **Wrap:** preload by stepping until `wall_x`=0, next step → erase x=0, paint at x=159.
- **Collision:**
  - step to `wall_x`=PLAYER_X with `player_y`=0 → `touched`=1 after CHECK, held through STOP; READY clears it.
  - Same with `player_y`=3 → `touched` stays 0.
- **Abort:** `state`→READY mid-PAINT → `plot`=0 next cycle, `wall_x`=159, `busy`=0.
- **Random gap:** with `WALL_GAP_RANDOM_EN`, two consecutive READY→MOVE cycles yield gap rows matching the LFSR reference model (seed 8'hA5).
